// File: rtl/sum_accumulator.sv
// sum_accumulator: adds COUNT consecutive WIDTH+1-bit adder samples into a full-precision
// block total on a registered valid/ready output. Define SUM_ACC_CLEAR_EN to add a synchronous clear.
module sum_accumulator #(
  parameter int WIDTH = 32,
  parameter int COUNT = 4,
  localparam int ACC_WIDTH = WIDTH + 1 + $clog2(COUNT),
  localparam int IDX_WIDTH = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef SUM_ACC_CLEAR_EN
  input  logic                 clear,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH:0]       in_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic [IDX_WIDTH-1:0] out_last_idx
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(COUNT - 1);
  localparam logic [IDX_WIDTH-1:0] ONE_IDX  = IDX_WIDTH'(1);

  state_t                 state_r;
  logic [IDX_WIDTH-1:0]   cnt_r;
  logic [ACC_WIDTH-1:0]   acc_r;
  logic [ACC_WIDTH-1:0]   out_acc_r;
  logic                   out_valid_r;

  logic                   clear_s;
  logic                   in_ready_s;
  logic                   in_xfer_s;
  logic                   out_xfer_s;
  logic [ACC_WIDTH-1:0]   in_ext_s;
  logic [ACC_WIDTH-1:0]   acc_base_s;
  logic [ACC_WIDTH-1:0]   sum_s;

`ifdef SUM_ACC_CLEAR_EN
  assign clear_s = clear;
`else
  assign clear_s = 1'b0;
`endif

  // Ready handshake: the only combinational path is out_ready -> in_ready while holding a result.
  always_comb begin
    in_ready_s = 1'b0;
    if (clear_s) begin
      in_ready_s = 1'b0;
    end else begin
      case (state_r)
        ACCUM:   in_ready_s = 1'b1;
        HOLD:    in_ready_s = out_ready;
        default: in_ready_s = 1'b0;
      endcase
    end
  end

  // Datapath: a stale acc_r is masked when starting a new block (cnt_r == 0).
  always_comb begin
    in_ext_s   = ACC_WIDTH'(in_sum);
    acc_base_s = {ACC_WIDTH{1'b0}};
    if (cnt_r == {IDX_WIDTH{1'b0}}) begin
      acc_base_s = {ACC_WIDTH{1'b0}};
    end else begin
      acc_base_s = acc_r;
    end
    sum_s      = acc_base_s + in_ext_s;
    in_xfer_s  = in_valid && in_ready_s;
    out_xfer_s = out_valid_r && out_ready && !clear_s;
  end

  // Block FSM: accumulates samples, parks the completed total in HOLD until it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ACCUM;
      cnt_r       <= {IDX_WIDTH{1'b0}};
      acc_r       <= {ACC_WIDTH{1'b0}};
      out_acc_r   <= {ACC_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else if (clear_s) begin
      state_r     <= ACCUM;
      cnt_r       <= {IDX_WIDTH{1'b0}};
      acc_r       <= {ACC_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (in_xfer_s) begin
            if (cnt_r == LAST_IDX) begin
              out_acc_r   <= sum_s;
              cnt_r       <= {IDX_WIDTH{1'b0}};
              state_r     <= HOLD;
              out_valid_r <= 1'b1;
            end else begin
              acc_r <= sum_s;
              cnt_r <= cnt_r + ONE_IDX;
            end
          end
        end
        HOLD: begin
          if (out_xfer_s) begin
            if (in_xfer_s) begin
              // The sample accepted alongside the handoff opens the next block.
              acc_r <= in_ext_s;
              if (COUNT == 1) begin
                out_acc_r <= in_ext_s;
              end else begin
                cnt_r       <= ONE_IDX;
                state_r     <= ACCUM;
                out_valid_r <= 1'b0;
              end
            end else begin
              state_r     <= ACCUM;
              out_valid_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r     <= ACCUM;
          cnt_r       <= {IDX_WIDTH{1'b0}};
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_s;
  assign out_valid    = out_valid_r;
  assign out_acc      = out_acc_r;
  assign out_last_idx = cnt_r;

endmodule

// File: tb/tb_sum_accumulator.sv
// Testbench for sum_accumulator: directed and random stimulus against a queue-based block-sum model.
module tb_sum_accumulator;
  localparam int W  = 35;
  localparam int C  = 4;
  localparam int AW = 38;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W:0]    in_sum;
  logic [AW-1:0] out_acc;
  logic [1:0]    out_last_idx;

  logic          v1, r1, rdy1, ov1;
  logic [W:0]    s1;
  logic [W:0]    acc1;
  logic [0:0]    idx1;

`ifdef SUM_ACC_CLEAR_EN
  logic          clear;
  logic          clear1;
`endif

  sum_accumulator #(.WIDTH(W), .COUNT(C)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SUM_ACC_CLEAR_EN
    .clear(clear),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_last_idx(out_last_idx)
  );

  sum_accumulator #(.WIDTH(W), .COUNT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef SUM_ACC_CLEAR_EN
    .clear(clear1),
`endif
    .in_valid(v1), .in_ready(rdy1), .in_sum(s1),
    .out_valid(ov1), .out_ready(r1), .out_acc(acc1),
    .out_last_idx(idx1)
  );

  always #5 clk = ~clk;

  int               n_tests = 0;
  int               n_fail  = 0;
  longint unsigned  q[$];
  bit               m_pend;
  logic [AW-1:0]    m_acc;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus on the COUNT=4 instance, predicted from block-sum rules.
  task automatic step(bit v, logic [W:0] s, bit r, bit clr);
    bit exp_rdy, ix, ox;
    longint unsigned t;
    @(negedge clk);
    in_valid  = v;
    in_sum    = s;
    out_ready = r;
`ifdef SUM_ACC_CLEAR_EN
    clear = clr;
`endif
    #1;
    exp_rdy = !clr && (!m_pend || r);
    check("in_ready", in_ready, exp_rdy);
    ix = v && exp_rdy;
    ox = m_pend && r && !clr;
    if (clr) begin
      q.delete();
      m_pend = 1'b0;
    end else begin
      if (ox) m_pend = 1'b0;
      if (ix) begin
        q.push_back(s);
        if (q.size() == C) begin
          t = 0;
          foreach (q[i]) t += q[i];
          m_acc  = t[AW-1:0];
          m_pend = 1'b1;
          q.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_pend);
    check("out_acc", out_acc, m_acc);
    check("out_last_idx", out_last_idx, q.size());
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 64'd0);
    check("rst_out_acc", out_acc, 64'd0);
    check("rst_last_idx", out_last_idx, 64'd0);
    check("rst_in_ready", in_ready, 64'd1);
    check("rst_c1_valid", ov1, 64'd0);
    q.delete();
    m_pend = 1'b0;
    m_acc  = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [W:0] rnd_sample();
    logic [63:0] tmp;
    tmp = {$urandom(), $urandom()};
    if ($urandom_range(0, 7) == 0) tmp = 64'hFFFF_FFFF_FFFF_FFFF;
    return tmp[W:0];
  endfunction

  initial begin
    logic [W:0] a, b, c, mx;
    rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; out_ready = 1'b0;
    v1 = 1'b0; s1 = '0; r1 = 1'b0;
`ifdef SUM_ACC_CLEAR_EN
    clear = 1'b0; clear1 = 1'b0;
`endif
    m_pend = 1'b0; m_acc = '0;
    do_reset();

    // Reset mid-block, then a fresh block of ones
    step(1'b1, 36'd3, 1'b1, 1'b0);
    step(1'b1, 36'd9, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 36'd1, 1'b1, 1'b0);
    check("t1_total", out_acc, 64'd4);
    step(1'b0, 36'd0, 1'b1, 1'b0);

    // 10,20,30,40: one-cycle out_valid with total 100
    step(1'b1, 36'd10, 1'b1, 1'b0);
    step(1'b1, 36'd20, 1'b1, 1'b0);
    step(1'b1, 36'd30, 1'b1, 1'b0);
    check("t2_not_yet", out_valid, 64'd0);
    step(1'b1, 36'd40, 1'b1, 1'b0);
    check("t2_total", out_acc, 64'd100);
    step(1'b0, 36'd0, 1'b1, 1'b0);
    check("t2_one_cycle", out_valid, 64'd0);

    // Max samples: no truncation
    mx = {(W+1){1'b1}};
    for (int i = 0; i < 4; i++) step(1'b1, mx, 1'b1, 1'b0);
    check("t3_max", out_acc, 64'h3F_FFFF_FFFC);
    step(1'b0, 36'd0, 1'b1, 1'b0);

    // Backpressure holds the result, then release with a simultaneous sample
    step(1'b1, 36'd10, 1'b0, 1'b0);
    step(1'b1, 36'd20, 1'b0, 1'b0);
    step(1'b1, 36'd30, 1'b0, 1'b0);
    step(1'b1, 36'd40, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, rnd_sample(), 1'b0, 1'b0);
      check("t4_hold_acc", out_acc, 64'd100);
      check("t4_hold_valid", out_valid, 64'd1);
    end
    step(1'b1, 36'd7, 1'b1, 1'b0);
    a = rnd_sample(); b = rnd_sample(); c = rnd_sample();
    step(1'b1, a, 1'b1, 1'b0);
    step(1'b1, b, 1'b1, 1'b0);
    step(1'b1, c, 1'b1, 1'b0);
    check("t4_total", out_acc, 64'd7 + 64'(a) + 64'(b) + 64'(c));
    step(1'b0, 36'd0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), rnd_sample(), 1'($urandom_range(0, 2) != 0), 1'b0);
    step(1'b0, 36'd0, 1'b1, 1'b0);
    step(1'b0, 36'd0, 1'b0, 1'b0);

    // COUNT=1 instance: streaming buffer with full throughput
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      v1 = 1'b1; s1 = 36'(i); r1 = 1'b1;
      #1;
      check("c1_in_ready", rdy1, 64'd1);
      @(posedge clk);
      #1;
      check("c1_valid", ov1, 64'd1);
      check("c1_acc", acc1, 64'(i));
    end
    @(negedge clk);
    v1 = 1'b1; s1 = 36'd99; r1 = 1'b0;
    #1;
    check("c1_bp_ready", rdy1, 64'd0);
    @(posedge clk);
    #1;
    check("c1_bp_acc", acc1, 64'd8);
    check("c1_bp_valid", ov1, 64'd1);
    @(negedge clk);
    v1 = 1'b0; r1 = 1'b1;
    @(posedge clk);
    #1;
    check("c1_drain", ov1, 64'd0);

`ifdef SUM_ACC_CLEAR_EN
    // Clear mid-block drops the partial block
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 36'd9, 1'b1, 1'b0);
    step(1'b1, 36'd9, 1'b1, 1'b1);
    check("clr_idx", out_last_idx, 64'd0);
    check("clr_no_out", out_valid, 64'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 36'd5, 1'b1, 1'b0);
    check("clr_total", out_acc, 64'd20);
    step(1'b0, 36'd0, 1'b1, 1'b0);
    // Clear while holding a result
    for (int i = 0; i < 4; i++) step(1'b1, 36'd2, 1'b0, 1'b0);
    step(1'b1, 36'd3, 1'b1, 1'b1);
    check("clr_hold_valid", out_valid, 64'd0);
    check("clr_hold_acc", out_acc, 64'd8);
    step(1'b0, 36'd0, 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
